gf180mcu_fd_sc_mcu7t5v0_aoi21_1_wrap: RTL and testbench

GF180MCU_FD_SC_MCU7T5V0_AOI21_1_WRAP -- requirements
Module: gf180mcu_fd_sc_mcu7t5v0_aoi21_1

---
 rtl/gf180mcu_fd_sc_mcu7t5v0_aoi21_1_wrap.sv | 73 +++++++
 tb/tb_gf180mcu_fd_sc_mcu7t5v0_aoi21_1_wrap.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/gf180mcu_fd_sc_mcu7t5v0_aoi21_1_wrap.sv
// AOI21 cell wrapper: ZN = ~((A1 & A2) | B), plus a registered copy of ZN
// and saturating rise/fall transition counters for that registered copy.
module gf180mcu_fd_sc_mcu7t5v0_aoi21_1_wrap #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             A1,
    input  logic             A2,
    input  logic             B,
    output logic             ZN,
    output logic             ZN_Q,
    output logic [CNT_W-1:0] ZN_RISE,
    output logic [CNT_W-1:0] ZN_FALL
);

    logic             zn_s;
    logic             zn_q_r;
    logic             primed_r;
    logic [CNT_W-1:0] rise_r;
    logic [CNT_W-1:0] fall_r;
    logic [CNT_W-1:0] rise_nxt_s;
    logic [CNT_W-1:0] fall_nxt_s;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == {CNT_W{1'b1}}) begin
            return v;
        end else begin
            return v + CNT_W'(1'b1);
        end
    endfunction

    // Cell function; 4-state operators give controlling-value X resolution.
    always_comb begin
        zn_s = ~((A1 & A2) | B);
    end

    // Edge detection compares the sampled ZN against the previous registered value.
    always_comb begin
        rise_nxt_s = rise_r;
        fall_nxt_s = fall_r;
        if (primed_r && (zn_q_r == 1'b0) && (zn_s == 1'b1)) begin
            rise_nxt_s = sat_inc(rise_r);
        end else if (primed_r && (zn_q_r == 1'b1) && (zn_s == 1'b0)) begin
            fall_nxt_s = sat_inc(fall_r);
        end else begin
            rise_nxt_s = rise_r;
            fall_nxt_s = fall_r;
        end
    end

    // Registered state; reset clears everything including the primed flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            zn_q_r   <= 1'b0;
            primed_r <= 1'b0;
            rise_r   <= {CNT_W{1'b0}};
            fall_r   <= {CNT_W{1'b0}};
        end else begin
            zn_q_r   <= zn_s;
            primed_r <= 1'b1;
            rise_r   <= rise_nxt_s;
            fall_r   <= fall_nxt_s;
        end
    end

    assign ZN      = zn_s;
    assign ZN_Q    = zn_q_r;
    assign ZN_RISE = rise_r;
    assign ZN_FALL = fall_r;

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0_aoi21_1_wrap.sv
// Directed self-checking bench for the AOI21 wrapper (default and CNT_W=2 instances).
module tb_gf180mcu_fd_sc_mcu7t5v0_aoi21_1_wrap;

    logic        clk;
    logic        clk_en;
    logic        rst;
    logic        a1;
    logic        a2;
    logic        b;
    logic        zn;
    logic        zn_q;
    logic [15:0] zn_rise;
    logic [15:0] zn_fall;
    logic        zn_s2;
    logic        zn_q_s2;
    logic [1:0]  zn_rise_s2;
    logic [1:0]  zn_fall_s2;

    int tests_run    = 0;
    int tests_failed = 0;

    gf180mcu_fd_sc_mcu7t5v0_aoi21_1_wrap dut (
        .clk(clk), .rst(rst), .A1(a1), .A2(a2), .B(b),
        .ZN(zn), .ZN_Q(zn_q), .ZN_RISE(zn_rise), .ZN_FALL(zn_fall)
    );

    gf180mcu_fd_sc_mcu7t5v0_aoi21_1_wrap #(.CNT_W(2)) dut_small (
        .clk(clk), .rst(rst), .A1(a1), .A2(a2), .B(b),
        .ZN(zn_s2), .ZN_Q(zn_q_s2), .ZN_RISE(zn_rise_s2), .ZN_FALL(zn_fall_s2)
    );

    initial clk = 1'b0;
    always #5 clk = clk_en ? ~clk : 1'b0;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_regs(input string tag, input logic q, input int r, input int f);
        check({tag, "_q"},    {31'd0, zn_q}, {31'd0, q});
        check({tag, "_rise"}, {16'd0, zn_rise}, r);
        check({tag, "_fall"}, {16'd0, zn_fall}, f);
    endtask

    logic [2:0] vec [8];
    logic       exp_zn [8];

    initial begin
        clk_en = 1'b0;
        rst    = 1'b1;
        a1 = 1'b0; a2 = 1'b0; b = 1'b0;

        // Truth table, clock stopped. Vector bits are {A1,A2,B}.
        vec[0] = 3'b000; exp_zn[0] = 1'b1;
        vec[1] = 3'b100; exp_zn[1] = 1'b1;
        vec[2] = 3'b010; exp_zn[2] = 1'b1;
        vec[3] = 3'b110; exp_zn[3] = 1'b0;
        vec[4] = 3'b001; exp_zn[4] = 1'b0;
        vec[5] = 3'b101; exp_zn[5] = 1'b0;
        vec[6] = 3'b011; exp_zn[6] = 1'b0;
        vec[7] = 3'b111; exp_zn[7] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            {a1, a2, b} = vec[i];
            #1;
            check($sformatf("tt_%b", vec[i]), {31'd0, zn}, {31'd0, exp_zn[i]});
        end

        // Controlling values dominate unknowns.
        a1 = 1'bx; a2 = 1'bx; b = 1'b1; #1;
        check("x_b1", {31'd0, zn}, 32'd0);
        a1 = 1'b0; a2 = 1'bx; b = 1'b0; #1;
        check("x_a1_0", {31'd0, zn}, 32'd1);

        // Reset for one edge.
        clk_en = 1'b1;
        a1 = 1'b0; a2 = 1'b0; b = 1'b0;
        rst = 1'b1;
        tick();
        check_regs("reset", 1'b0, 0, 0);

        // Prime: first edge loads ZN_Q but does not count.
        rst = 1'b0;
        tick();
        check_regs("prime", 1'b1, 0, 0);

        // Toggle B for 6 edges.
        b = 1'b1; tick(); check_regs("tog1", 1'b0, 0, 1);
        b = 1'b0; tick(); check_regs("tog2", 1'b1, 1, 1);
        b = 1'b1; tick(); check_regs("tog3", 1'b0, 1, 2);
        b = 1'b0; tick(); check_regs("tog4", 1'b1, 2, 2);
        b = 1'b1; tick(); check_regs("tog5", 1'b0, 2, 3);
        b = 1'b0; tick(); check_regs("tog6", 1'b1, 3, 3);

        // Steady ZN: counters hold.
        a1 = 1'b1; tick(); check_regs("hold", 1'b1, 3, 3);
        a1 = 1'b0;

        // Glitch between edges is invisible.
        #2 b = 1'b1; #1 b = 1'b0;
        tick(); check_regs("glitch", 1'b1, 3, 3);

        // Two more pairs: small instance saturates at 3.
        b = 1'b1; tick();
        b = 1'b0; tick();
        b = 1'b1; tick();
        b = 1'b0; tick();
        check_regs("pairs5", 1'b1, 5, 5);
        check("sat_rise", {30'd0, zn_rise_s2}, 32'd3);
        check("sat_fall", {30'd0, zn_fall_s2}, 32'd3);
        check("sat_q",    {31'd0, zn_q_s2},    32'd1);

        // Mid-run reset discards counts; ZN still follows inputs.
        b = 1'b1;
        rst = 1'b1;
        tick();
        check_regs("midrst", 1'b0, 0, 0);
        check("midrst_small_rise", {30'd0, zn_rise_s2}, 32'd0);
        check("midrst_zn0", {31'd0, zn}, 32'd0);
        b = 1'b0; #1;
        check("midrst_zn1", {31'd0, zn}, 32'd1);

        // First edge after reset loads without counting, then counting resumes.
        rst = 1'b0;
        tick(); check_regs("reprime", 1'b1, 0, 0);
        b = 1'b1; tick(); check_regs("refall", 1'b0, 0, 1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
